// File: rtl/time_pkg.sv
// Shared constants for the six-digit multiplexed time display.
// Segment codes, digit indices, colon digit positions and BCD bundle type.
package time_pkg;

  localparam int NDIG = 6;

  localparam logic [2:0] DIG_SU = 3'd0;
  localparam logic [2:0] DIG_ST = 3'd1;
  localparam logic [2:0] DIG_MU = 3'd2;
  localparam logic [2:0] DIG_MT = 3'd3;
  localparam logic [2:0] DIG_HU = 3'd4;
  localparam logic [2:0] DIG_HT = 3'd5;

  localparam logic [2:0] COLON_A = DIG_MU;
  localparam logic [2:0] COLON_B = DIG_HU;

  // {g,f,e,d,c,b,a}, entry i is the glyph for decimal digit i
  localparam logic [9:0][6:0] SEG_TBL = {
    7'b1101111,
    7'b1111111,
    7'b0000111,
    7'b1111101,
    7'b1101101,
    7'b1100110,
    7'b1001111,
    7'b1011011,
    7'b0000110,
    7'b0111111
  };

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
    logic       ovr;
  } bcd_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_DASH;
    if (d <= 4'd9) s = SEG_TBL[d];
    return s;
  endfunction

endpackage

// File: rtl/time_display_if.sv
// Bundle between the time counter and the display driver.
// master: drives seconds/minutes/hours, reads an/seg/dp. slave: the display.
interface time_display_if;

  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output seconds,
    output minutes,
    output hours,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  seconds,
    input  minutes,
    input  hours,
    output an,
    output seg,
    output dp
  );

endinterface

// File: rtl/time_display_bin2bcd.sv
// Combinational 8-bit binary to two-digit BCD converter.
// Ports: bin_i value in; tens_o/units_o BCD digits; ovr_o set when bin_i > 99.
module bin2bcd
  import time_pkg::*;
(
  input  logic [7:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       ovr_o
);

  logic [3:0] tens;

  // Threshold ladder instead of a divider; the range is tiny.
  always_comb begin
    tens = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (bin_i >= 8'(10 * k)) tens = 4'(k);
    end
  end

  always_comb begin
    ovr_o   = (bin_i > 8'd99);
    tens_o  = 4'd0;
    units_o = 4'd0;
    if (!ovr_o) begin
      tens_o  = tens;
      units_o = 4'(bin_i - {4'd0, tens} * 8'd10);
    end
  end

endmodule

// File: rtl/time_display.sv
// Six-digit multiplexed HH:MM:SS display driver with frame snapshots.
// Ports: clk, reset (sync, active-high); bus.slave carries time in, an/seg/dp out.
module time_display
  import time_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic           clk,
  input  logic           reset,
  time_display_if.slave  bus
);

  logic [7:0] presc_q, presc_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sec_snap_q, sec_snap_d;
  logic [7:0] min_snap_q, min_snap_d;
  logic [7:0] hr_snap_q, hr_snap_d;
  logic [7:0] sec_prev_q;
  logic       colon_q, colon_d;
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       wrap;
  logic       cap;
  logic [7:0] field;
  bcd_t       bcd;

  // Scan timing: digit advances once per SCAN_DIV cycles.
  always_comb begin
    wrap    = (presc_q == 8'(SCAN_DIV - 1));
    presc_d = wrap ? 8'd0 : presc_q + 8'd1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = (idx_q >= DIG_HT) ? DIG_SU : idx_q + 3'd1;
    end
    cap = wrap && (idx_q >= DIG_HT);
  end

  // Whole-frame snapshot taken on the 5->0 step so a frame never tears.
  always_comb begin
    sec_snap_d = sec_snap_q;
    min_snap_d = min_snap_q;
    hr_snap_d  = hr_snap_q;
    if (cap) begin
      sec_snap_d = bus.seconds;
      min_snap_d = bus.minutes;
      hr_snap_d  = bus.hours;
    end
  end

  assign colon_d = colon_q ^ (bus.seconds != sec_prev_q);

  // Outputs describe idx_d so they line up with the registered index;
  // next-state snapshots are used so digit 0 shows the fresh capture.
  always_comb begin
    unique case (1'b1)
      (idx_d[2:1] == 2'd0): field = sec_snap_d;
      (idx_d[2:1] == 2'd1): field = min_snap_d;
      default:              field = hr_snap_d;
    endcase
  end

  bin2bcd u_bcd (
    .bin_i   (field),
    .tens_o  (bcd.tens),
    .units_o (bcd.units),
    .ovr_o   (bcd.ovr)
  );

  always_comb begin
    an_d  = 6'b000001 << idx_d;
    seg_d = SEG_DASH;
    if (!bcd.ovr) begin
      seg_d = seg_code(idx_d[0] ? bcd.tens : bcd.units);
    end
    dp_d = colon_d && ((idx_d == COLON_A) || (idx_d == COLON_B));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= 8'd0;
      idx_q      <= DIG_SU;
      sec_snap_q <= 8'd0;
      min_snap_q <= 8'd0;
      hr_snap_q  <= 8'd0;
      sec_prev_q <= 8'd0;
      colon_q    <= 1'b1;
      an_q       <= 6'b000001;
      seg_q      <= SEG_ZERO;
      dp_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      sec_snap_q <= sec_snap_d;
      min_snap_q <= min_snap_d;
      hr_snap_q  <= hr_snap_d;
      sec_prev_q <= bus.seconds;
      colon_q    <= colon_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display at SCAN_DIV=1 and SCAN_DIV=4.
// Expected per-cycle outputs are queued up front; a negedge monitor checks them.
module tb_time_display;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] DS = 7'b1000000;

  typedef struct {
    int         c;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] sec_r = 8'd56;
  logic [7:0] min_r = 8'd34;
  logic [7:0] hr_r  = 8'd12;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q1[$];
  exp_t q4[$];

  time_display_if bus1 ();
  time_display_if bus4 ();

  assign bus1.seconds = sec_r;
  assign bus1.minutes = min_r;
  assign bus1.hours   = hr_r;
  assign bus4.seconds = sec_r;
  assign bus4.minutes = min_r;
  assign bus4.hours   = hr_r;

  time_display #(.SCAN_DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  time_display #(.SCAN_DIV(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic e1(input int c, input int d, input logic [6:0] s,
                    input logic p);
    exp_t e;
    e.c = c; e.an = 6'(1 << d); e.seg = s; e.dp = p;
    q1.push_back(e);
  endtask

  task automatic e4(input int c, input int d, input logic [6:0] s,
                    input logic p);
    exp_t e;
    e.c = c; e.an = 6'(1 << d); e.seg = s; e.dp = p;
    q4.push_back(e);
  endtask

  // One SCAN_DIV=1 frame; p is the dp level on the two colon digits.
  task automatic f1(input int c0,
                    input logic [6:0] s0, input logic [6:0] s1,
                    input logic [6:0] s2, input logic [6:0] s3,
                    input logic [6:0] s4, input logic [6:0] s5,
                    input logic p);
    e1(c0,     0, s0, 1'b0);
    e1(c0 + 1, 1, s1, 1'b0);
    e1(c0 + 2, 2, s2, p);
    e1(c0 + 3, 3, s3, 1'b0);
    e1(c0 + 4, 4, s4, p);
    e1(c0 + 5, 5, s5, 1'b0);
  endtask

  task automatic chk(input string nm, input exp_t e, input logic [5:0] a,
                     input logic [6:0] s, input logic d);
    checks++;
    if ({a, s, d} !== {e.an, e.seg, e.dp}) begin
      errors++;
      $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               nm, e.c, a, s, d, e.an, e.seg, e.dp);
    end
  endtask

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].c <= cyc) begin
      chk("div1", q1.pop_front(), bus1.an, bus1.seg, bus1.dp);
    end
    while (q4.size() > 0 && q4[0].c <= cyc) begin
      chk("div4", q4.pop_front(), bus4.an, bus4.seg, bus4.dp);
    end
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    e1(1, 0, S0, 1'b0);
    e1(2, 0, S0, 1'b0);
    f1(3,  S0, S0, S0, S0, S0, S0, 1'b0);
    f1(9,  S6, S5, S4, S3, S2, S1, 1'b0);
    f1(15, S6, S5, S5, S3, S2, S1, 1'b1);
    f1(21, S7, S5, S5, S3, S2, S1, 1'b1);
    f1(27, S7, S5, DS, DS, S7, S0, 1'b0);
    e1(33, 0, S8, 1'b0);
    e1(34, 1, S5, 1'b0);
    f1(35, S0, S0, S0, S0, S0, S0, 1'b0);
    f1(41, S8, S5, DS, DS, S7, S0, 1'b0);

    e4(1, 0, S0, 1'b0);
    e4(2, 0, S0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 4; j++) begin
        e4(3 + 4 * k + j, k, S0, (k == 4));
      end
    end
    for (int j = 0; j < 4; j++) e4(27 + j, 0, S7, 1'b0);
    for (int j = 0; j < 4; j++) e4(31 + j, 1, S5, 1'b0);
    for (int j = 0; j < 4; j++) e4(35 + j, 0, S0, 1'b0);

    at(3);  reset = 1'b0;
    at(10); min_r = 8'd35;
    at(15); sec_r = 8'd57;
    at(21); hr_r = 8'd7; min_r = 8'd100;
    at(27); sec_r = 8'd58;
    at(34); reset = 1'b1;
    at(35); reset = 1'b0;
    at(48);

    if (q1.size() + q4.size() != 0) begin
      $display("FAIL leftover got %0d unchecked want 0", q1.size() + q4.size());
      checks += q1.size() + q4.size();
      errors += q1.size() + q4.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
